// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential 32-bit divider.
// Holds the FSM state encoding, the iteration count and a magnitude helper.
package div_seq_pkg;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } divState_e;

    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic isNeg);
        return isNeg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
// Handshake: start is sampled only while the divider is IDLE; done pulses for one cycle with results valid.
interface div_seq_if #(parameter int WIDTH = 32);

    logic             start;
    logic             isSigned;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             annul;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, isSigned, dividend, divisor, annul,
        input  stall, done, quotient, remainder
    );

    modport slave (
        input  start, isSigned, dividend, divisor, annul,
        output stall, done, quotient, remainder
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and insert the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted = {remIn, quoIn[WIDTH-1]};
        trial   = shifted - {2'b00, divisor};
        // A clear sign bit means the divisor fits: keep the difference and emit a 1.
        if (!trial[WIDTH+1]) begin
            remOut = trial[WIDTH:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end else begin
            remOut = shifted[WIDTH:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential 32-cycle restoring divider (DIV/DIVU) with divide-by-zero
// short path, pipeline stall request and annul (flush) support.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset,
    div_seq_if.slave   io,
    output divState_e  dbgState
);

    divState_e          state, stateNext;
    logic [CNT_W-1:0]   count;
    logic [WIDTH:0]     remReg;
    logic [WIDTH-1:0]   quoReg;
    logic [WIDTH-1:0]   divReg;
    logic               signedReg;
    logic               dividendNeg;
    logic               divisorNeg;
    logic [WIDTH:0]     stepRem;
    logic [WIDTH-1:0]   stepQuo;
    logic [WIDTH-1:0]   quotientReg;
    logic [WIDTH-1:0]   remainderReg;
    logic               enterDone;
    logic               negQuo;
    logic               negRem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divReg),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (io.start) stateNext = (io.divisor == '0) ? BYZERO : RUN;
            BYZERO:  stateNext = DONE;
            RUN:     if (count == CNT_W'(DIV_CYCLES - 1)) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // Flush wins over everything, including a fresh start.
        if (io.annul) stateNext = IDLE;
    end

    assign enterDone = (stateNext == DONE) && (state != DONE);
    assign negQuo    = signedReg && (dividendNeg ^ divisorNeg);
    assign negRem    = signedReg && dividendNeg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            remReg       <= '0;
            quoReg       <= '0;
            divReg       <= '0;
            signedReg    <= 1'b0;
            dividendNeg  <= 1'b0;
            divisorNeg   <= 1'b0;
            quotientReg  <= '0;
            remainderReg <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && stateNext == RUN) begin
                count       <= '0;
                remReg      <= '0;
                signedReg   <= io.isSigned;
                dividendNeg <= io.dividend[WIDTH-1];
                divisorNeg  <= io.divisor[WIDTH-1];
                quoReg      <= magnitude(io.dividend, io.isSigned && io.dividend[WIDTH-1]);
                divReg      <= magnitude(io.divisor, io.isSigned && io.divisor[WIDTH-1]);
            end else if (state == RUN) begin
                count  <= count + 1'b1;
                remReg <= stepRem;
                quoReg <= stepQuo;
            end
            // Results change only when DONE is entered; the last step's outputs are used directly.
            if (enterDone) begin
                if (state == BYZERO) begin
                    quotientReg  <= '0;
                    remainderReg <= '0;
                end else begin
                    quotientReg  <= magnitude(stepQuo, negQuo);
                    remainderReg <= magnitude(stepRem[WIDTH-1:0], negRem);
                end
            end
        end
    end

    assign io.stall     = !io.annul && ((state == BYZERO) || (state == RUN) ||
                                        (state == IDLE && io.start));
    assign io.done      = (state == DONE);
    assign io.quotient  = quotientReg;
    assign io.remainder = remainderReg;
    assign dbgState     = state;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, stall window, signed
// corner cases, divide-by-zero, annul and asynchronous reset mid-operation.
module tb_div_seq;
    import div_seq_pkg::*;

    logic      clock;
    logic      reset;
    divState_e dbgState;
    int        checksTotal;
    int        checksPassed;

    div_seq_if #(.WIDTH(32)) io ();

    div_seq #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .io       (io),
        .dbgState (dbgState)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checksTotal++;
        if (got === exp) checksPassed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at a negedge; issues one divide and checks latency, stall window and results.
    task automatic runOp(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expQ,
                         input logic [31:0] expR, input int expLat);
        int   lat;
        logic stallOk;
        io.isSigned = sgn;
        io.dividend = a;
        io.divisor  = b;
        io.start    = 1'b1;
        #1 check({tag, " stall@start"}, 32'(io.stall), 32'd1);
        lat     = -1;
        stallOk = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1 io.start = 1'b0;
            @(negedge clock);
            if (io.done) begin
                lat = k;
                break;
            end
            if (!io.stall) stallOk = 1'b0;
        end
        check({tag, " latency"}, 32'(lat), 32'(expLat));
        check({tag, " stall window"}, 32'(stallOk), 32'd1);
        if (lat > 0) begin
            check({tag, " quotient"}, io.quotient, expQ);
            check({tag, " remainder"}, io.remainder, expR);
            // A start raised during DONE must be ignored and must not stall.
            io.start    = 1'b1;
            io.dividend = 32'd77;
            io.divisor  = 32'd5;
            #1 check({tag, " stall@done"}, 32'(io.stall), 32'd0);
            @(posedge clock);
            #1 io.start = 1'b0;
            @(negedge clock);
            check({tag, " idle after done"}, 32'(dbgState), 32'(IDLE));
            check({tag, " no second done"}, 32'(io.done), 32'd0);
        end
    endtask

    initial begin
        logic sawDone;
        checksTotal  = 0;
        checksPassed = 0;
        reset        = 1'b0;
        io.start     = 1'b0;
        io.isSigned  = 1'b0;
        io.dividend  = '0;
        io.divisor   = '0;
        io.annul     = 1'b0;
        repeat (2) @(negedge clock);
        check("reset state", 32'(dbgState), 32'(IDLE));
        check("reset quotient", io.quotient, 32'd0);
        check("reset remainder", io.remainder, 32'd0);
        check("reset stall", 32'(io.stall), 32'd0);
        check("reset done", 32'(io.done), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        runOp("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        runOp("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        runOp("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        runOp("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 33);
        runOp("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
        runOp("divu 5/10", 1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 33);
        runOp("divu big/big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 33);
        runOp("div by zero", 1'b0, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 2);
        runOp("div minint/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);

        // Annul on the 10th RUN cycle; results from minint/-1 must survive.
        io.isSigned = 1'b0;
        io.dividend = 32'd1000;
        io.divisor  = 32'd3;
        io.start    = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1 io.start = 1'b0;
            @(negedge clock);
        end
        check("annul pre state", 32'(dbgState), 32'(RUN));
        io.annul = 1'b1;
        #1 check("annul stall", 32'(io.stall), 32'd0);
        @(posedge clock);
        #1 io.annul = 1'b0;
        @(negedge clock);
        check("annul next state", 32'(dbgState), 32'(IDLE));
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (io.done) sawDone = 1'b1;
        end
        check("annul no done", 32'(sawDone), 32'd0);
        check("annul keep quotient", io.quotient, 32'h8000_0000);
        check("annul keep remainder", io.remainder, 32'd0);

        // Asynchronous reset on the 5th RUN cycle.
        io.dividend = 32'd50;
        io.divisor  = 32'd5;
        io.start    = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock);
            #1 io.start = 1'b0;
            @(negedge clock);
        end
        reset = 1'b0;
        #1;
        check("rst quotient", io.quotient, 32'd0);
        check("rst remainder", io.remainder, 32'd0);
        check("rst stall", 32'(io.stall), 32'd0);
        check("rst done", 32'(io.done), 32'd0);
        check("rst state", 32'(dbgState), 32'(IDLE));
        @(negedge clock);
        reset = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (io.done) sawDone = 1'b1;
        end
        check("rst lost op", 32'(sawDone), 32'd0);
        runOp("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
